// File: rtl/pwm_pkg.sv
// Shared defaults and duty-step arithmetic for the PWM demonstrator.
package pwm_pkg;

    localparam int unsigned WIDTH      = 8;
    localparam int unsigned STEP       = 16;
    localparam int unsigned PRESCALE   = 1;
    localparam int unsigned DUTY_RESET = 1 << (WIDTH - 1);

    typedef logic [WIDTH:0] duty_t;

    // Saturating step of the duty setting; simultaneous inc/dec cancel out.
    function automatic int unsigned next_duty(
        input int unsigned cur,
        input logic        inc,
        input logic        dec,
        input int unsigned step,
        input int unsigned full
    );
        int unsigned nxt;
        nxt = cur;
        if (inc && !dec) begin
            nxt = (cur + step >= full) ? full : cur + step;
        end else if (dec && !inc) begin
            nxt = (cur <= step) ? 0 : cur - step;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/pwm_core.sv
// Prescaled PWM counter with a period-aligned duty shadow and registered compare.
module pwm_core #(
    parameter int unsigned WIDTH    = pwm_pkg::WIDTH,
    parameter int unsigned PRESCALE = pwm_pkg::PRESCALE
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH:0]   duty_target,
    output logic             pwm_q
);

    localparam int unsigned PS_W     = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int unsigned DW       = WIDTH + 1;
    localparam int unsigned DUTY_RST = 1 << (WIDTH - 1);

    logic [PS_W-1:0]  ps;
    logic [WIDTH-1:0] cnt;
    logic [WIDTH:0]   duty_active;
    logic             tick_c;

    assign tick_c = (ps == PS_W'(PRESCALE - 1));

    // Shadow only reloads on the wrap tick so a period is never cut short.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ps          <= '0;
            cnt         <= '0;
            duty_active <= DW'(DUTY_RST);
            pwm_q       <= 1'b0;
        end else begin
            ps <= tick_c ? '0 : ps + PS_W'(1);
            if (tick_c) begin
                cnt <= cnt + WIDTH'(1);
                if (cnt == '1) begin
                    duty_active <= duty_target;
                end
            end
            pwm_q <= ({1'b0, cnt} < duty_active);
        end
    end

endmodule

// File: rtl/pwm_top_level.sv
// Board top: button conditioning, saturating duty register and PWM on LEDG[0].
module pwm_top_level #(
    parameter int unsigned WIDTH    = pwm_pkg::WIDTH,
    parameter int unsigned STEP     = pwm_pkg::STEP,
    parameter int unsigned PRESCALE = pwm_pkg::PRESCALE
) (
    input  logic        CLOCK_50,
    input  logic        reset,
    input  logic [35:0] GPIO,
    output logic [7:0]  LEDG
);

    import pwm_pkg::next_duty;

    localparam int unsigned DW       = WIDTH + 1;
    localparam int unsigned FULL     = 1 << WIDTH;
    localparam int unsigned DUTY_RST = 1 << (WIDTH - 1);

    // Bit 0 carries the increase button, bit 1 the decrease button.
    logic [1:0]     sync1;
    logic [1:0]     sync2;
    logic [1:0]     prev;
    logic           inc_c;
    logic           dec_c;
    logic [WIDTH:0] duty_target;
    logic           pwm_q;
    logic           unused_gpio;

    assign unused_gpio = ^GPIO[33:0];

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
            prev  <= '0;
        end else begin
            sync1 <= GPIO[35:34];
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    assign inc_c = sync2[0] & ~prev[0];
    assign dec_c = sync2[1] & ~prev[1];

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            duty_target <= DW'(DUTY_RST);
        end else begin
            duty_target <= DW'(next_duty(32'(duty_target), inc_c, dec_c, STEP, FULL));
        end
    end

    pwm_core #(
        .WIDTH    (WIDTH),
        .PRESCALE (PRESCALE)
    ) u_core (
        .clk         (CLOCK_50),
        .rst         (reset),
        .duty_target (duty_target),
        .pwm_q       (pwm_q)
    );

    // Upper LEDs show the top seven bits of the duty setting.
    assign LEDG = {duty_target[WIDTH -: 7], pwm_q};

endmodule

// File: tb/tb_pwm_top_level.sv
// Directed bench for pwm_top_level with a cycle-level behavioural model.
module tb_pwm_top_level;

    logic        CLOCK_50 = 1'b0;
    logic        reset    = 1'b0;
    logic [35:0] GPIO     = '0;
    logic [7:0]  LEDG;

    int tests = 0;
    int fails = 0;

    pwm_top_level #(.WIDTH(8), .STEP(16), .PRESCALE(1)) dut (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .GPIO     (GPIO),
        .LEDG     (LEDG)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    // Model: edges since reset release, period duty, and button sample history
    int       m_n      = 0;
    int       m_duty   = 128;
    int       m_active = 128;
    logic     m_pwm    = 1'b0;
    logic [3:0] h_inc  = '0;
    logic [3:0] h_dec  = '0;
    logic     chk_en   = 1'b0;

    always @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            m_n      = 0;
            m_duty   = 128;
            m_active = 128;
            m_pwm    = 1'b0;
            h_inc    = '0;
            h_dec    = '0;
        end else begin
            logic ev_inc, ev_dec;
            m_n   = m_n + 1;
            m_pwm = (((m_n - 1) % 256) < m_active);
            if (m_n % 256 == 0) m_active = m_duty;
            h_inc  = {h_inc[2:0], GPIO[34]};
            h_dec  = {h_dec[2:0], GPIO[35]};
            // A level first seen high two edges ago (low three ago) is an event now
            ev_inc = h_inc[2] & ~h_inc[3];
            ev_dec = h_dec[2] & ~h_dec[3];
            if (ev_inc && !ev_dec)
                m_duty = (m_duty + 16 > 256) ? 256 : m_duty + 16;
            else if (ev_dec && !ev_inc)
                m_duty = (m_duty < 16) ? 0 : m_duty - 16;
        end
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    always @(negedge CLOCK_50) begin
        if (chk_en) begin
            logic [7:0] exp;
            exp = {7'(m_duty >> 2), m_pwm};
            check("ledg_model", 16'(LEDG), 16'(exp));
        end
    end

    task automatic do_reset(input int cycles);
        @(negedge CLOCK_50);
        #2 reset = 1'b1;
        #1 check("ledg_in_reset", 16'(LEDG), 16'h40);
        repeat (cycles) begin
            @(negedge CLOCK_50);
            check("ledg_hold_reset", 16'(LEDG), 16'h40);
        end
        @(negedge CLOCK_50);
        #2 reset = 1'b0;
    endtask

    task automatic pulse(input int b);
        @(negedge CLOCK_50);
        GPIO[b] = 1'b1;
        repeat (2) @(negedge CLOCK_50);
        GPIO[b] = 1'b0;
        repeat (3) @(negedge CLOCK_50);
    endtask

    // Counts LEDG[0] high samples over the next whole PWM period.
    task automatic count_period(output int highs);
        int guard = 0;
        highs = 0;
        while ((m_n % 256 != 0) && guard < 300) begin
            @(negedge CLOCK_50);
            guard++;
        end
        if (guard >= 300) check("period_align_timeout", 16'(guard), 16'(0));
        repeat (256) begin
            @(negedge CLOCK_50);
            if (LEDG[0] === 1'b1) highs++;
        end
    endtask

    task automatic single_inc_check();
        @(negedge CLOCK_50);
        GPIO[34] = 1'b1;
        repeat (2) @(negedge CLOCK_50);
        GPIO[34] = 1'b0;
        @(negedge CLOCK_50);
        check("single_inc_led", 16'(LEDG[7:1]), 16'd36);
    endtask

    initial begin
        int h;
        #1 reset = 1'b1;
        chk_en = 1'b1;

        // Reset and 50% baseline
        do_reset(3);
        @(negedge CLOCK_50);
        check("first_edge_ledg", 16'(LEDG), 16'h41);
        count_period(h);
        check("reset_high_time", 16'(h), 16'd128);

        // Single increase: current period untouched, next one 144
        fork
            count_period(h);
            single_inc_check();
        join
        check("inc_period_old", 16'(h), 16'd128);
        count_period(h);
        check("inc_period_new", 16'(h), 16'd144);

        // Decrease saturation
        for (int i = 0; i < 10; i++) pulse(35);
        check("dec_sat_led", 16'(LEDG[7:1]), 16'd0);
        count_period(h);
        check("dec_sat_high", 16'(h), 16'd0);

        // Increase saturation from reset
        do_reset(2);
        for (int i = 0; i < 10; i++) pulse(34);
        check("inc_sat_led", 16'(LEDG[7:1]), 16'd64);
        count_period(h);
        check("inc_sat_high", 16'(h), 16'd256);
        count_period(h);
        check("inc_sat_high2", 16'(h), 16'd256);

        // Simultaneous rise and held-high inputs, with noise on unused pins
        do_reset(2);
        @(negedge CLOCK_50);
        GPIO[35:34] = 2'b11;
        repeat (20) begin
            @(negedge CLOCK_50);
            GPIO[33:0] = 34'($urandom);
        end
        check("simul_led", 16'(LEDG[7:1]), 16'd32);
        GPIO[35:34] = 2'b00;
        repeat (4) @(negedge CLOCK_50);
        GPIO[34] = 1'b1;
        repeat (20) begin
            @(negedge CLOCK_50);
            GPIO[33:0] = 34'($urandom);
        end
        check("held_single_step", 16'(LEDG[7:1]), 16'd36);
        GPIO = '0;

        // Reset in the middle of a period discards the stepped duty
        do_reset(2);
        for (int i = 0; i < 3; i++) pulse(34);
        check("step_to_176", 16'(LEDG[7:1]), 16'd44);
        repeat (100) @(negedge CLOCK_50);
        #2 reset = 1'b1;
        #1 check("mid_reset_ledg", 16'(LEDG), 16'h40);
        repeat (2) @(negedge CLOCK_50);
        #2 reset = 1'b0;
        count_period(h);
        check("after_mid_reset_high", 16'(h), 16'd128);
        check("after_mid_reset_led", 16'(LEDG[7:1]), 16'd32);

        repeat (3) @(negedge CLOCK_50);
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
